// File: rtl/uprog_sequencer.sv
// Micro-program sequencer: owns the PC register fed by the next-address mux and
// steps one pass of the micro-program per vector element with a start/done handshake.
module uprog_sequencer #(
   parameter int W        = 4,
   parameter int PROG_LEN = 6,
   parameter int IDX_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] n_elems,
   input  logic             stall,
   input  logic [W-1:0]     pc_next,
   output logic [W-1:0]     pc,
   output logic             jump,
   output logic             uop_valid,
   output logic [IDX_W-1:0] idx,
   output logic             last_elem,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [W-1:0] LAST_PC = W'(PROG_LEN - 1);

   state_t           r_state;
   logic [W-1:0]     r_pc;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_n;

   logic w_run;
   logic w_jump;
   logic w_last;

   assign w_run  = (r_state == S_RUN);
   assign w_jump = w_run && (r_pc == LAST_PC);
   // RUN is only entered with a non-zero count, so r_n-1 never wraps while it matters
   assign w_last = w_run && (r_idx == (r_n - IDX_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_idx   <= '0;
         r_n     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pc    <= '0;
                  r_idx   <= '0;
                  r_n     <= n_elems;
                  r_state <= (n_elems == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  // the mux supplies 0 on the final jump, so pc leaves RUN at 0
                  r_pc <= pc_next;
                  if (w_jump) begin
                     if (w_last) r_state <= S_DONE;
                     else        r_idx   <= r_idx + IDX_W'(1);
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pc        = r_pc;
   assign idx       = r_idx;
   assign jump      = w_jump;
   assign uop_valid = w_run && !stall;
   assign last_elem = w_last;
   assign busy      = w_run;
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_uprog_sequencer.sv
// Bench for uprog_sequencer: directed scenarios then random traffic, every cycle
// checked against a model that tracks progress as a count of issued micro-ops.
module tb_uprog_sequencer;

   localparam int W        = 4;
   localparam int PROG_LEN = 6;
   localparam int IDX_W    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [IDX_W-1:0] n_elems = '0;
   logic             stall = 1'b0;
   logic [W-1:0]     pc_next;
   logic [W-1:0]     pc;
   logic             jump;
   logic             uop_valid;
   logic [IDX_W-1:0] idx;
   logic             last_elem;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   // Environment: the next-address mux
   assign pc_next = jump ? '0 : W'(pc + W'(1));

   uprog_sequencer #(.W(W), .PROG_LEN(PROG_LEN), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_elems(n_elems), .stall(stall),
      .pc_next(pc_next), .pc(pc), .jump(jump), .uop_valid(uop_valid), .idx(idx),
      .last_elem(last_elem), .busy(busy), .done(done)
   );

   // Reference model: mode 0=IDLE 1=RUN 2=DONE; progress is the number of
   // micro-ops issued in the current run, from which pc and idx follow.
   int m_mode;
   int m_uops;
   int m_n;
   int m_idx_hold;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;
   int done_cyc;
   bit seen_done;
   int uv_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_uops = 0; m_n = 0; m_idx_hold = 0;
   endtask

   task automatic cyc(input logic r, input logic s, input int n, input logic st);
      bit run;
      int e_pc, e_idx;
      rst = r; start = s; n_elems = IDX_W'(n); stall = st;
      #4;
      run   = (m_mode == 1);
      e_pc  = run ? (m_uops % PROG_LEN) : 0;
      e_idx = run ? (m_uops / PROG_LEN) : m_idx_hold;
      check("pc",        32'(pc),        32'(e_pc));
      check("idx",       32'(idx),       32'(e_idx));
      check("busy",      32'(busy),      32'(run));
      check("done",      32'(done),      32'(m_mode == 2));
      check("jump",      32'(jump),      32'(run && e_pc == PROG_LEN - 1));
      check("uop_valid", 32'(uop_valid), 32'(run && !st));
      check("last_elem", 32'(last_elem), 32'(run && e_idx == m_n - 1));
      if (done === 1'b1 && !seen_done) begin seen_done = 1; done_cyc = cyc_no; end
      if (uop_valid === 1'b1) uv_cnt++;
      @(posedge clk);
      if (r) model_reset();
      else begin
         case (m_mode)
            0: if (s) begin
                  m_n = n; m_uops = 0; m_idx_hold = 0;
                  m_mode = (n == 0) ? 2 : 1;
               end
            1: if (!st) begin
                  m_uops++;
                  if (m_uops == m_n * PROG_LEN) begin
                     m_mode = 2; m_idx_hold = m_n - 1;
                  end
               end
            default: m_mode = 0;
         endcase
      end
      cyc_no++;
      #1;
   endtask

   task automatic arm();
      seen_done = 0; done_cyc = -1000; uv_cnt = 0;
   endtask

   task automatic run_to_done(input int budget);
      int g;
      g = 0;
      while (!seen_done && g < budget) begin
         cyc(1'b0, 1'b0, 0, 1'b0);
         g++;
      end
   endtask

   int c0;

   initial begin
      model_reset();
      arm();
      repeat (2) @(posedge clk);
      #1;

      // 1: reset then idle
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 0, 1'b0);

      // 2: nominal run, n=3
      arm(); c0 = cyc_no;
      cyc(1'b0, 1'b1, 3, 1'b0);
      run_to_done(40);
      check("nominal_latency", 32'(done_cyc - c0), 32'(3 * PROG_LEN + 1));
      check("nominal_uops",    32'(uv_cnt),        32'(3 * PROG_LEN));
      cyc(1'b0, 1'b0, 0, 1'b0);

      // 3: stall three cycles at pc=3, idx=1
      arm(); c0 = cyc_no;
      cyc(1'b0, 1'b1, 3, 1'b0);
      for (int i = 0; i < PROG_LEN + 3; i++) cyc(1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 1'b1);
      run_to_done(40);
      check("stall_latency", 32'(done_cyc - c0), 32'(3 * PROG_LEN + 4));
      cyc(1'b0, 1'b0, 0, 1'b0);

      // 4: stall on the jump cycle of element 0
      arm();
      cyc(1'b0, 1'b1, 2, 1'b0);
      for (int i = 0; i < PROG_LEN - 1; i++) cyc(1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 0, 1'b1);
      run_to_done(40);
      cyc(1'b0, 1'b0, 0, 1'b0);

      // 5: degenerate counts
      arm(); c0 = cyc_no;
      cyc(1'b0, 1'b1, 0, 1'b0);
      run_to_done(10);
      check("n0_latency", 32'(done_cyc - c0), 32'd1);
      check("n0_uops",    32'(uv_cnt),        32'd0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      arm(); c0 = cyc_no;
      cyc(1'b0, 1'b1, 1, 1'b0);
      run_to_done(20);
      check("n1_latency", 32'(done_cyc - c0), 32'(PROG_LEN + 1));
      check("n1_uops",    32'(uv_cnt),        32'(PROG_LEN));
      cyc(1'b0, 1'b0, 0, 1'b0);

      // 6a: reset mid-run at pc=2, idx=1
      arm();
      cyc(1'b0, 1'b1, 3, 1'b0);
      for (int i = 0; i < PROG_LEN + 2; i++) cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 1'b0);
      check("rst_no_done", 32'(seen_done), 32'd0);

      // 6b: start and n_elems=7 while busy, start in DONE, then start in IDLE
      arm(); c0 = cyc_no;
      cyc(1'b0, 1'b1, 2, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 7, 1'b0);
      while (!seen_done && cyc_no - c0 < 40) cyc(1'b0, 1'b1, 7, 1'b0);
      check("busy_start_ignored", 32'(done_cyc - c0), 32'(2 * PROG_LEN + 1));
      cyc(1'b0, 1'b0, 0, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic r, s, st;
         int n;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 30);
         st = ($urandom_range(0, 99) < 25);
         n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
         cyc(r, s, n, st);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uprog_sequencer.md
Name: uprog_sequencer

Overview:
- Owns the micro-program PC register for the cosine-similarity datapath, directly downstream of the next-address mux.
- Registers `pc_next` from the mux and drives `pc` back to it, with `jump` as the mux select.
- Sequences one pass of the micro-program per vector element, counts elements, and signals completion with a start/done handshake.
- `pc` also addresses the micro-program ROM, which issues control words to the datapath.

Parameters:
- W, 4, PC width; must match the next-address mux width.
- PROG_LEN, 6, micro-instructions per element; valid PC values are 0..PROG_LEN-1; legal range 1..2^W.
- IDX_W, 8, width of element index and element count.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin a computation; sampled only in IDLE.
- n_elems, in, IDX_W, number of vector elements; latched when start is accepted.
- stall, in, 1, datapath/memory not ready; freezes sequencing.
- pc_next, in, W, next address from the mux: 0 when jump=1, else pc+1.
- pc, out, W, current micro-program address, registered.
- jump, out, 1, mux select; combinational.
- uop_valid, out, 1, the control word at pc executes this cycle.
- idx, out, IDX_W, current element index, registered.
- last_elem, out, 1, idx == latched n_elems-1 while in RUN.
- busy, out, 1, state is RUN.
- done, out, 1, one-cycle completion pulse.

Behaviour:
- States and transitions:
  - IDLE → RUN on start when n_elems≠0.
  - IDLE → DONE on start when n_elems==0. No micro-instructions are issued.
  - RUN → DONE on an advance with jump=1 and last_elem=1.
  - DONE → IDLE unconditionally after one cycle.
- Reset (rst=1 at an edge, from any state, including mid-RUN):
  - state=IDLE, pc=0, idx=0, latched count=0.
  - All outputs 0 the following cycle. Any in-flight computation is abandoned; no done pulse.
- Combinational outputs:
  - jump = (state==RUN) && (pc==PROG_LEN-1).
  - uop_valid = (state==RUN) && !stall.
  - busy = (state==RUN).
  - done = (state==DONE).
- Advance: occurs in RUN when stall=0.
  - pc <= pc_next.
  - If jump, idx <= idx+1, except on the last element, where idx holds its value and the state moves to DONE.
- Stall: when stall=1 in RUN, pc, idx and state hold, uop_valid=0, and jump still reflects pc.
- Start acceptance:
  - In IDLE, start=1 sets pc<=0, idx<=0 and latches n_elems.
  - start in RUN or DONE is ignored; n_elems changes after acceptance have no effect.
- Leaving RUN: pc is 0 on exit (the mux supplied 0 on the final jump); pc stays 0 through DONE and IDLE.
- Latency and throughput:
  - First uop_valid occurs the cycle after start is accepted.
  - One micro-instruction per unstalled cycle.
  - With no stalls, done is high exactly n_elems·PROG_LEN+1 cycles after the start cycle.
- Width rules:
  - idx arithmetic is modulo 2^IDX_W; n_elems=2^IDX_W is not representable, and the maximum count is 2^IDX_W-1.
  - PROG_LEN=1: jump is asserted on every RUN cycle.
- Back-to-back runs: start asserted in the DONE cycle is ignored. The earliest new start is the following cycle (IDLE).
- pc_next is trusted: the block does not check it.
  - The bench must model the mux: pc_next = jump ? 0 : pc+1, width W.

Test Plan:
1. Reset then idle (rst 2 cycles, start=0 for 5 cycles) → pc=0, idx=0, busy=0, done=0, jump=0, uop_valid=0 throughout.
2. Nominal run (PROG_LEN=6, n_elems=3, no stall, start at cycle 0):
   - pc sequence 0..5 repeated 3 times over cycles 1–18; idx=0,1,2 per pass.
   - jump high at cycles 6, 12 and 18; last_elem high on cycles 13–18.
   - done high only at cycle 19, busy=0 from cycle 19.
3. Stall mid-run: stall=1 for 3 cycles while pc=3, idx=1 → pc/idx hold at 3/1, uop_valid=0 for those cycles, done delayed by exactly 3 cycles versus scenario 2.
4. Stall on the jump cycle: stall=1 while pc=5, idx=0 → jump stays 1, idx stays 0; on release, pc=0 and idx=1 the next cycle.
5. Degenerate counts:
   - n_elems=0 → done pulses the cycle after start, with no uop_valid.
   - n_elems=1 → exactly 6 uop_valid cycles, then done.
6. Reset and start interactions:
   - rst at pc=2, idx=1 → next cycle IDLE with pc=0, idx=0, no done.
   - start re-asserted while busy, and n_elems changed to 7 mid-run → ignored; the run completes with the original count.
